// File: rtl/counter_enable_scheduler.sv
// counter_enable_scheduler: drives the enable and reset_value inputs of a downstream
// strobe counter. It issues single-cycle enable pulses at a programmable division rate,
// only after the counter reports ready, with a guaranteed idle gap after each pulse.
// It also applies host reload requests only inside safe windows.
//
// Build option: define SCHED_MISSED_COUNT_EN to build the saturating missed-tick counter.
// Without it, `missed` is tied to zero. Dropped ticks are still dropped.
module counter_enable_scheduler #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DIV_WIDTH  = 8,
    parameter int unsigned OVF_WIDTH  = 8,
    parameter int unsigned INIT_VALUE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 load_req,
    input  logic [WIDTH-1:0]     load_value,
    output logic                 load_ack,
    input  logic                 cnt_ready,
    input  logic                 cnt_strobe,
    output logic                 enable,
    output logic [WIDTH-1:0]     reset_value,
    output logic [OVF_WIDTH-1:0] missed,
    output logic                 busy
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StWaitReady,
        StPulse,
        StHoldoff
    } state_e;

    state_e               state_q;
    logic [DIV_WIDTH-1:0] presc_q;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [DIV_WIDTH-1:0] reload_val;
    logic [WIDTH-1:0]     load_clamped;
    logic                 tick;
    logic                 pending_q;
    logic                 first_q;
    logic                 load_win;

    // Clamp the period and reload value, derive the tick, and decide whether a reload is safe now
    always_comb begin
        div_eff      = (div_value < DIV_WIDTH'(3)) ? DIV_WIDTH'(3) : div_value;
        reload_val   = div_eff - DIV_WIDTH'(1);
        tick         = run && (state_q != StIdle) && (presc_q == '0);
        load_clamped = (load_value < WIDTH'(2)) ? WIDTH'(2) : load_value;
        // Counter is quiescent: strobe without a concurrent enable, idle, or never enabled yet.
        // A request is not taken in the cycle its previous ack is still showing.
        load_win     = load_req && !load_ack &&
                       ((cnt_strobe && !enable) || (state_q == StIdle) || first_q);
    end

    // Prescaler: loads on leaving IDLE, reloads at zero, and clears whenever run is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (!run) begin
            presc_q <= '0;
        end else if ((state_q == StIdle) || (presc_q == '0)) begin
            presc_q <= reload_val;
        end else begin
            presc_q <= presc_q - DIV_WIDTH'(1);
        end
    end

    // Scheduler FSM with registered enable/busy, plus the reload handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            enable      <= 1'b0;
            busy        <= 1'b0;
            pending_q   <= 1'b0;
            first_q     <= 1'b1;
            load_ack    <= 1'b0;
            reset_value <= WIDTH'(INIT_VALUE);
        end else begin
            enable    <= 1'b0;
            pending_q <= 1'b0;
            load_ack  <= load_win;
            if (load_win) begin
                reset_value <= load_clamped;
            end
            case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q <= StWaitTick;
                        busy    <= 1'b1;
                    end
                end
                StWaitTick: begin
                    if (!run) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (tick) begin
                        state_q <= StWaitReady;
                    end
                end
                StWaitReady: begin
                    if (!run) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (cnt_ready) begin
                        state_q <= StPulse;
                        enable  <= 1'b1;
                        first_q <= 1'b0;
                    end
                end
                StPulse: begin
                    // A pulse always completes; a tick seen now is held for the HOLDOFF exit
                    if (!run) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        state_q   <= StHoldoff;
                        pending_q <= tick;
                    end
                end
                StHoldoff: begin
                    if (!run) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (pending_q || tick) begin
                        state_q <= StWaitReady;
                    end else begin
                        state_q <= StWaitTick;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCHED_MISSED_COUNT_EN
    logic [OVF_WIDTH-1:0] missed_q;

    // Count ticks that land while a previous tick still waits for ready; saturate at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            missed_q <= '0;
        end else if (tick && (state_q == StWaitReady) && (missed_q != '1)) begin
            missed_q <= missed_q + OVF_WIDTH'(1);
        end
    end

    assign missed = missed_q;
`else
    assign missed = '0;
`endif

endmodule
